// File: rtl/snake_pkg.sv
// Shared grid constants, pixel/direction codes and cell helpers
// for the snake game-state stage.
package snake_pkg;

    localparam int GRID_W     = 40;
    localparam int GRID_H     = 30;
    localparam int CELL_SHIFT = 4;

    localparam logic [1:0] PIX_NONE = 2'b00;
    localparam logic [1:0] PIX_HEAD = 2'b01;
    localparam logic [1:0] PIX_BODY = 2'b10;
    localparam logic [1:0] PIX_WALL = 2'b11;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [5:0] START_X = 6'd20;
    localparam logic [4:0] START_Y = 5'd15;

    typedef struct packed {
        logic [5:0] x;
        logic [4:0] y;
    } cell_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    function automatic logic is_wall(input cell_t c);
        return (c.x == 6'd0) || (c.x == 6'(GRID_W - 1)) ||
               (c.y == 5'd0) || (c.y == 5'(GRID_H - 1));
    endfunction

    // Opposite directions share bit 1 and differ in bit 0.
    function automatic logic is_reverse(input logic [1:0] a,
                                        input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    function automatic cell_t step(input cell_t c, input logic [1:0] d);
        cell_t n;
        n = c;
        case (d)
            DIR_UP:    n.y = c.y - 5'd1;
            DIR_DOWN:  n.y = c.y + 5'd1;
            DIR_LEFT:  n.x = c.x - 6'd1;
            default:   n.x = c.x + 6'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/snake_body_if.sv
// Control, pixel-address and status bundle between the game
// controller, vga_control and the snake body stage.
interface snake_body_if;

    logic       start;
    logic       move_tick;
    logic       dir_valid;
    logic [1:0] dir_in;
    logic       grow;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [1:0] snake;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [6:0] length;
    logic       dead;
    logic       hit_wall;
    logic       hit_body;

    modport master (
        output start, move_tick, dir_valid, dir_in, grow, x_pos, y_pos,
        input  snake, head_x, head_y, length, dead, hit_wall, hit_body
    );

    modport slave (
        input  start, move_tick, dir_valid, dir_in, grow, x_pos, y_pos,
        output snake, head_x, head_y, length, dead, hit_wall, hit_body
    );

endinterface

// File: rtl/snake_pixel_lookup.sv
// Classifies the addressed pixel against all segments and the wall,
// registered so the code lags x_pos/y_pos by one clock.
module snake_pixel_lookup
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              x_pos,
    input  logic [9:0]              y_pos,
    input  cell_t [MAX_LEN-1:0]     seg,
    input  logic [6:0]              length,
    output logic [1:0]              snake
);

    cell_t      pc;
    logic       in_range;
    logic       head_m;
    logic       body_m;
    logic       wall_m;
    logic [1:0] code;

    always_comb begin
        pc.x     = x_pos[9:CELL_SHIFT];
        pc.y     = y_pos[8:CELL_SHIFT];
        in_range = (x_pos < 10'd640) && (y_pos < 10'd480);
        head_m   = (length != 7'd0) && (seg[0] == pc);
        body_m   = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((7'(i) < length) && (seg[i] == pc)) begin
                body_m = 1'b1;
            end
        end
        wall_m = is_wall(pc);
    end

    always_comb begin
        code = PIX_NONE;
        if (in_range) begin
            if (head_m) begin
                code = PIX_HEAD;
            end else if (body_m) begin
                code = PIX_BODY;
            end else if (wall_m) begin
                code = PIX_WALL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snake <= PIX_NONE;
        end else begin
            snake <= code;
        end
    end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake game state: FSM, segment shift register, direction/grow
// handling and one-cycle collision check ahead of vga_control.
module snake_body_ctrl
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3
) (
    input  logic         clk,
    input  logic         rst,
    snake_body_if.slave  bus
);

    state_t               state;
    state_t               state_nx;
    cell_t [MAX_LEN-1:0]  seg;
    logic [1:0]           dir;
    logic [1:0]           pending_dir;
    logic [1:0]           eff_dir;
    logic [6:0]           len;
    logic                 grow_pending;
    logic                 hit_wall;
    logic                 hit_body;
    logic                 dir_ok;
    logic                 do_move;
    logic                 growing;
    logic                 wall_hit;
    logic                 body_hit;
    logic                 restart;
    cell_t                nh;
    logic [1:0]           pix;

    always_comb begin
        dir_ok  = bus.dir_valid && !is_reverse(bus.dir_in, dir);
        eff_dir = dir_ok ? bus.dir_in : pending_dir;
        // start always wins over a coincident move
        do_move = (state == ST_RUN) && bus.move_tick && !bus.start;
        growing = (grow_pending || bus.grow) && (len < 7'(MAX_LEN));
        nh       = step(seg[0], eff_dir);
        wall_hit = is_wall(nh);
        body_hit = 1'b0;
        // The tail cell is free to enter unless the snake grows.
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((7'(i) < len) &&
                !((7'(i) == len - 7'd1) && !growing) &&
                (seg[i] == nh)) begin
                body_hit = 1'b1;
            end
        end
        restart = (state == ST_DEAD) && bus.start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (do_move && (wall_hit || body_hit)) begin
                    state_nx = ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (bus.start) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg[i].x <= (i < INIT_LEN) ? START_X - 6'(i) : START_X;
                seg[i].y <= START_Y;
            end
            dir          <= DIR_RIGHT;
            pending_dir  <= DIR_RIGHT;
            len          <= 7'(INIT_LEN);
            grow_pending <= 1'b0;
            hit_wall     <= 1'b0;
            hit_body     <= 1'b0;
        end else if (state == ST_RUN) begin
            if (do_move) begin
                grow_pending <= 1'b0;
                if (wall_hit) begin
                    hit_wall <= 1'b1;
                end else if (body_hit) begin
                    hit_body <= 1'b1;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg[i] <= seg[i-1];
                    end
                    seg[0]      <= nh;
                    dir         <= eff_dir;
                    pending_dir <= eff_dir;
                    if (growing) begin
                        len <= len + 7'd1;
                    end
                end
            end else begin
                if (dir_ok) begin
                    pending_dir <= bus.dir_in;
                end
                if (bus.grow) begin
                    grow_pending <= 1'b1;
                end
            end
        end
    end

    snake_pixel_lookup #(
        .MAX_LEN (MAX_LEN)
    ) u_lookup (
        .clk    (clk),
        .rst    (rst),
        .x_pos  (bus.x_pos),
        .y_pos  (bus.y_pos),
        .seg    (seg),
        .length (len),
        .snake  (pix)
    );

    always_comb begin
        bus.snake    = pix;
        bus.head_x   = seg[0].x;
        bus.head_y   = seg[0].y;
        bus.length   = len;
        bus.dead     = (state == ST_DEAD);
        bus.hit_wall = hit_wall;
        bus.hit_body = hit_body;
    end

endmodule

// File: doc/snake_body_ctrl.md
Name: snake_body_ctrl

Overview:
Game-state stage directly upstream of vga_control.
- Holds the snake segment list on a 40x30 cell grid (16 px cells) and advances it on each move tick.
- Accepts direction and grow requests, and detects wall and self collisions.
- Classifies the pixel addressed by vga_control's x_pos/y_pos into the 2-bit snake code that vga_control consumes.
- Runs on the pixel clock.

Parameters:
MAX_LEN, 16, maximum number of segments (head included); range 4..64.
INIT_LEN, 3, segment count after reset/restart; range 2..MAX_LEN.

Ports:
clk  in  1  pixel clock (same clock as vga_display).
rst  in  1  synchronous reset, active-high.
start  in  1  one-cycle pulse; IDLE->RUN, DEAD->IDLE (restart).
move_tick  in  1  one-cycle pulse; advance snake by one cell.
dir_valid  in  1  qualifies dir_in.
dir_in  in  2  00 up, 01 down, 10 left, 11 right.
grow  in  1  one-cycle pulse; snake lengthens on the next move.
x_pos  in  10  pixel column from vga_control.
y_pos  in  10  pixel row from vga_control.
snake  out  2  pixel code: 00 none, 01 head, 10 body, 11 wall.
head_x  out  6  head cell column (0..39).
head_y  out  5  head cell row (0..29).
length  out  7  current segment count.
dead  out  1  high while in DEAD.
hit_wall  out  1  sticky cause flag, cleared on restart.
hit_body  out  1  sticky cause flag, cleared on restart.

Behaviour:
Grid and wall:
- Cell coordinates: cx = x_pos[9:4], cy = y_pos[8:4].
- Wall cells: cx==0, cx==39, cy==0, cy==29.

Reset / restart value:
- State IDLE; dir = right.
- Segments: seg[0] = (20,15), seg[i] = (20-i,15) for i < INIT_LEN.
- Outputs: length = INIT_LEN, head_x = 20, head_y = 15, snake = 00, dead/hit_wall/hit_body = 0, grow_pending = 0.

FSM states:
- IDLE: start -> RUN. move_tick, grow and dir_valid are ignored.
- RUN: normal operation (move handling below).
- DEAD: segments are frozen; all inputs except start are ignored. start -> IDLE with the reset configuration.

Direction handling (RUN only):
- dir_valid loads dir_in into pending_dir unless it is the reverse of the dir used for the last move.
- A reversing request is dropped with no other effect.
- A dir_valid in the same cycle as move_tick applies to that move.

Grow handling:
- grow sets grow_pending.
- grow_pending is cleared by the next executed move.
- If length == MAX_LEN, the move still clears grow_pending but length does not change.

Move (move_tick in RUN), decided in one cycle:
- nh = seg[0] stepped by the effective dir.
- If nh is a wall cell: -> DEAD, hit_wall = 1, segments unchanged.
- Else if nh equals any seg[i], i < length, excluding seg[length-1] when no growth occurs: -> DEAD, hit_body = 1. Moving into the cell the tail vacates is legal.
- Else: seg[i] <= seg[i-1] for i >= 1; seg[0] <= nh; length increments if growing and below MAX_LEN.
- New head_x/head_y are visible the cycle after move_tick.
- A move_tick arriving while already DEAD has no effect.

Pixel classification:
- snake is registered, with exactly 1 cycle latency from x_pos/y_pos. vga_display's color pipeline is aligned to this.
- Priority: head (seg[0]) > body (seg[1..length-1]) > wall > none.
- x_pos >= 640 or y_pos >= 480 gives 00.
- Segments at index >= length never match.
- Classification runs in every state; in IDLE and DEAD it shows the held snake.

Simultaneous events:
- start and move_tick in the same cycle: start wins and the move is discarded.
- rst overrides everything, including a move in progress.

Decomposition:
Package snake_pkg holds:
- GRID_W = 40, GRID_H = 30, CELL_SHIFT = 4.
- Code constants PIX_NONE/HEAD/BODY/WALL.
- DIR_UP/DOWN/LEFT/RIGHT.
- START_X = 20, START_Y = 15.
- Typedef for a cell coordinate {6-bit x, 5-bit y}.

Sub-module snake_pixel_lookup:
- Parallel compare of the pixel cell against MAX_LEN segments plus the wall check.
- Output register for snake.

The FSM, segment shift register and collision check stay in snake_body_ctrl.

Test Plan:
1. Reset, then scan x_pos=320,y_pos=240 -> snake=01 one cycle later; x_pos=304 -> 10; x_pos=0 -> 11; x_pos=100,y_pos=100 -> 00; x_pos=700 -> 00.
2. start, then 5 move_tick -> head_x=25, head_y=15, length=3. dir_valid left is ignored; dir_valid up then move -> head (25,14).
3. grow, then 2 move_tick -> length=4 after first move, 4 after second; grow repeated at length=MAX_LEN -> length stays 16.
4. Run right from start for 19 moves -> head (39 blocked); 19th move sets dead=1, hit_wall=1, head_x stays 38.
5. Length 5 with moves up, left, down -> hit_body=1, dead=1. Length 4 closing a loop into the vacating tail cell -> no death.
6. In DEAD pulse start -> IDLE with reset configuration and flags cleared. Assert rst mid-RUN with move_tick high -> reset values next cycle.
